// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Multicycle control FSM for a small ARM-style datapath.
//               Fetches into an instruction register, decodes from that
//               register only, and sequences EXEC / MEM / WB with ready
//               handshakes. Holds the {N,Z,V,C} flag register.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    input  logic        carry_out,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        UncondBr,
    output logic        BrTaken,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        ALUSrc,
    output logic        weFlags,
    output logic [2:0]  ALUOp,
    output logic [3:0]  flags,
    output logic        Illegal,
    output logic        InstrDone,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        MEM    = 3'b011,
        WB     = 3'b100
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic [3:0]  r_flags;

    // Opcode decode, always from the latched instruction register
    logic w_addi, w_adds, w_and, w_b, w_blt, w_cbz, w_eor;
    logic w_ldur, w_lsr, w_stur, w_subs, w_legal;

    assign w_addi  = (r_ir[31:22] == 10'b1001000100);
    assign w_adds  = (r_ir[31:21] == 11'b10101011000);
    assign w_and   = (r_ir[31:21] == 11'b10001010000);
    assign w_b     = (r_ir[31:26] == 6'b000101);
    assign w_blt   = (r_ir[31:24] == 8'b01010100) && (r_ir[4:0] == 5'b01011);
    assign w_cbz   = (r_ir[31:24] == 8'b10110100);
    assign w_eor   = (r_ir[31:21] == 11'b11001010000);
    assign w_ldur  = (r_ir[31:21] == 11'b11111000010);
    assign w_lsr   = (r_ir[31:22] == 10'b1101001101);
    assign w_stur  = (r_ir[31:21] == 11'b11111000000);
    assign w_subs  = (r_ir[31:21] == 11'b11101011000);
    assign w_legal = w_addi | w_adds | w_and | w_b | w_blt | w_cbz | w_eor |
                     w_ldur | w_lsr | w_stur | w_subs;

    // Ungated control values; reset masks them at the ports
    logic       w_irwrite, w_pcwrite, w_uncondbr, w_brtaken, w_reg2loc;
    logic       w_regwrite, w_memread, w_memwrite, w_memtoreg, w_alusrc;
    logic       w_weflags, w_illegal, w_done;
    logic [2:0] w_aluop;

    // State, instruction register and flag register; reset aborts any access
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= FETCH;
            r_ir    <= 32'h0;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (r_state == FETCH && imem_ready)
                r_ir <= instruction;
            if (w_weflags)
                r_flags <= {negative, zero, overflow, carry_out};
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        w_next     = FETCH;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_uncondbr = 1'b0;
        w_brtaken  = 1'b0;
        w_reg2loc  = 1'b0;
        w_regwrite = 1'b0;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_alusrc   = 1'b0;
        w_weflags  = 1'b0;
        w_illegal  = 1'b0;
        w_done     = 1'b0;
        w_aluop    = 3'b000;
        case (r_state)
            FETCH: begin
                w_irwrite = imem_ready;
                w_next    = imem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                w_reg2loc = ~(w_cbz | w_stur);
                if (w_legal) begin
                    w_next = EXEC;
                end else begin
                    w_illegal = 1'b1;
                    w_pcwrite = 1'b1;
                    w_done    = 1'b1;
                    w_next    = FETCH;
                end
            end
            EXEC: begin
                if (w_b || w_blt || w_cbz) begin
                    w_pcwrite = 1'b1;
                    w_done    = 1'b1;
                    w_next    = FETCH;
                    if (w_b) begin
                        w_uncondbr = 1'b1;
                        w_brtaken  = 1'b1;
                    end else if (w_blt) begin
                        // Signed less-than uses the stored flags, not the live ALU
                        w_brtaken = r_flags[3] ^ r_flags[1];
                    end else begin
                        w_brtaken = zero;
                    end
                end else if (w_ldur || w_stur) begin
                    w_aluop  = 3'b010;
                    w_alusrc = 1'b1;
                    w_next   = MEM;
                end else begin
                    w_next = WB;
                    if (w_addi) begin
                        w_aluop  = 3'b010;
                        w_alusrc = 1'b1;
                    end else if (w_adds) begin
                        w_aluop   = 3'b010;
                        w_weflags = 1'b1;
                    end else if (w_subs) begin
                        w_aluop   = 3'b011;
                        w_weflags = 1'b1;
                    end else if (w_and) begin
                        w_aluop = 3'b100;
                    end else if (w_eor) begin
                        w_aluop = 3'b110;
                    end else begin
                        w_aluop = 3'b001;
                    end
                end
            end
            MEM: begin
                w_aluop    = 3'b010;
                w_alusrc   = 1'b1;
                w_memread  = w_ldur;
                w_memwrite = w_stur;
                if (dmem_ready) begin
                    w_next    = w_ldur ? WB : FETCH;
                    w_pcwrite = w_stur;
                    w_done    = w_stur;
                end else begin
                    w_next = MEM;
                end
            end
            WB: begin
                w_regwrite = 1'b1;
                w_pcwrite  = 1'b1;
                w_done     = 1'b1;
                w_memtoreg = w_ldur;
                w_next     = FETCH;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    assign IRWrite   = reset & w_irwrite;
    assign PCWrite   = reset & w_pcwrite;
    assign UncondBr  = reset & w_uncondbr;
    assign BrTaken   = reset & w_brtaken;
    assign Reg2Loc   = reset & w_reg2loc;
    assign RegWrite  = reset & w_regwrite;
    assign MemRead   = reset & w_memread;
    assign MemWrite  = reset & w_memwrite;
    assign MemToReg  = reset & w_memtoreg;
    assign ALUSrc    = reset & w_alusrc;
    assign weFlags   = reset & w_weflags;
    assign Illegal   = reset & w_illegal;
    assign InstrDone = reset & w_done;
    assign ALUOp     = reset ? w_aluop : 3'b000;
    assign flags     = r_flags;
    assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Randomized self-checking bench for multicycle_controller.
//               Each instruction is expanded into its expected cycle sequence
//               and every cycle's state, controls and flags are compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        imem_ready, dmem_ready;
    logic        zero, negative, overflow, carry_out;
    logic        IRWrite, PCWrite, UncondBr, BrTaken, Reg2Loc, RegWrite;
    logic        MemRead, MemWrite, MemToReg, ALUSrc, weFlags, Illegal, InstrDone;
    logic [2:0]  ALUOp;
    logic [3:0]  flags;
    logic [2:0]  state;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .zero(zero), .negative(negative), .overflow(overflow), .carry_out(carry_out),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .UncondBr(UncondBr), .BrTaken(BrTaken),
        .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .ALUSrc(ALUSrc), .weFlags(weFlags), .ALUOp(ALUOp),
        .flags(flags), .Illegal(Illegal), .InstrDone(InstrDone), .state(state)
    );

    always #5 clk = ~clk;

    // Control vector bit positions
    localparam int B_IRW = 15, B_PCW = 14, B_UNC = 13, B_BRT = 12, B_R2L = 11;
    localparam int B_RGW = 10, B_MRD = 9, B_MWR = 8, B_M2R = 7, B_ALS = 6, B_WEF = 5;
    localparam int B_ILL = 1, B_DONE = 0;

    localparam int C_ADDI = 0, C_ADDS = 1, C_AND = 2, C_B = 3, C_BLT = 4, C_CBZ = 5;
    localparam int C_EOR = 6, C_LDUR = 7, C_LSR = 8, C_STUR = 9, C_SUBS = 10, C_ILL = 11;

    localparam int P_FWAIT = 0, P_FETCH = 1, P_DEC = 2, P_EXEC = 3;
    localparam int P_MEMW = 4, P_MEMR = 5, P_WB = 6;

    logic [15:0] obs_ctrl;
    assign obs_ctrl = {IRWrite, PCWrite, UncondBr, BrTaken, Reg2Loc, RegWrite, MemRead,
                       MemWrite, MemToReg, ALUSrc, weFlags, ALUOp, Illegal, InstrDone};

    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_flags;
    bit         frc_en = 1'b0;
    logic [3:0] frc_nzvc = 4'b0000;

    function automatic int classify(input logic [31:0] w);
        if (w[31:22] == 10'b1001000100) return C_ADDI;
        if (w[31:21] == 11'b10101011000) return C_ADDS;
        if (w[31:21] == 11'b10001010000) return C_AND;
        if (w[31:26] == 6'b000101) return C_B;
        if (w[31:24] == 8'b01010100 && w[4:0] == 5'b01011) return C_BLT;
        if (w[31:24] == 8'b10110100) return C_CBZ;
        if (w[31:21] == 11'b11001010000) return C_EOR;
        if (w[31:21] == 11'b11111000010) return C_LDUR;
        if (w[31:22] == 10'b1101001101) return C_LSR;
        if (w[31:21] == 11'b11111000000) return C_STUR;
        if (w[31:21] == 11'b11101011000) return C_SUBS;
        return C_ILL;
    endfunction

    function automatic logic [31:0] make_instr(input int cls);
        logic [31:0] r;
        r = $urandom;
        case (cls)
            C_ADDI: return {10'b1001000100, r[21:0]};
            C_ADDS: return {11'b10101011000, r[20:0]};
            C_AND:  return {11'b10001010000, r[20:0]};
            C_B:    return {6'b000101, r[25:0]};
            C_BLT:  return {8'b01010100, r[23:5], 5'b01011};
            C_CBZ:  return {8'b10110100, r[23:0]};
            C_EOR:  return {11'b11001010000, r[20:0]};
            C_LDUR: return {11'b11111000010, r[20:0]};
            C_LSR:  return {10'b1101001101, r[21:0]};
            C_STUR: return {11'b11111000000, r[20:0]};
            C_SUBS: return {11'b11101011000, r[20:0]};
            default: begin
                for (int k = 0; k < 100; k++) begin
                    r = $urandom;
                    if (classify(r) == C_ILL) return r;
                end
                return 32'hFFFF_FFFF;
            end
        endcase
    endfunction

    // Runs one instruction from FETCH, checking every cycle against the
    // cycle sequence implied by its class and the ready wait counts.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input string tag);
        int          cls, p, base, cyc, done_at;
        int          phases[$];
        logic [3:0]  nzvc;
        logic [2:0]  e_state;
        logic [15:0] e_ctrl;
        cls = classify(ins);
        for (int i = 0; i < iw; i++) phases.push_back(P_FWAIT);
        phases.push_back(P_FETCH);
        phases.push_back(P_DEC);
        if (cls != C_ILL) begin
            phases.push_back(P_EXEC);
            if (cls == C_LDUR || cls == C_STUR) begin
                for (int i = 0; i < dw; i++) phases.push_back(P_MEMW);
                phases.push_back(P_MEMR);
            end
            if (cls != C_B && cls != C_BLT && cls != C_CBZ && cls != C_STUR)
                phases.push_back(P_WB);
        end
        case (cls)
            C_ILL:                base = 2;
            C_B, C_BLT, C_CBZ:    base = 3;
            C_LDUR:               base = 5;
            default:              base = 4;
        endcase
        if (cls == C_LDUR || cls == C_STUR) base = base + dw;
        base = base + iw;
        done_at = -1;
        cyc = 0;
        foreach (phases[j]) begin
            p = phases[j];
            nzvc = (frc_en && p == P_EXEC) ? frc_nzvc : 4'($urandom);
            {negative, zero, overflow, carry_out} = nzvc;
            imem_ready  = (p == P_FETCH) ? 1'b1 : (p == P_FWAIT) ? 1'b0 : 1'($urandom);
            instruction = (p == P_FETCH) ? ins : $urandom;
            dmem_ready  = (p == P_MEMR) ? 1'b1 : (p == P_MEMW) ? 1'b0 : 1'($urandom);
            e_ctrl = 16'h0;
            case (p)
                P_FWAIT: e_state = 3'd0;
                P_FETCH: begin e_state = 3'd0; e_ctrl[B_IRW] = 1'b1; end
                P_DEC: begin
                    e_state = 3'd1;
                    e_ctrl[B_R2L] = !(cls == C_CBZ || cls == C_STUR);
                    if (cls == C_ILL) begin
                        e_ctrl[B_ILL] = 1'b1; e_ctrl[B_PCW] = 1'b1; e_ctrl[B_DONE] = 1'b1;
                    end
                end
                P_EXEC: begin
                    e_state = 3'd2;
                    case (cls)
                        C_ADDI, C_LDUR, C_STUR: begin e_ctrl[4:2] = 3'b010; e_ctrl[B_ALS] = 1'b1; end
                        C_ADDS: begin e_ctrl[4:2] = 3'b010; e_ctrl[B_WEF] = 1'b1; end
                        C_SUBS: begin e_ctrl[4:2] = 3'b011; e_ctrl[B_WEF] = 1'b1; end
                        C_AND:  e_ctrl[4:2] = 3'b100;
                        C_EOR:  e_ctrl[4:2] = 3'b110;
                        C_LSR:  e_ctrl[4:2] = 3'b001;
                        default: begin
                            e_ctrl[B_PCW] = 1'b1; e_ctrl[B_DONE] = 1'b1;
                            if (cls == C_B) begin e_ctrl[B_UNC] = 1'b1; e_ctrl[B_BRT] = 1'b1; end
                            else if (cls == C_BLT) e_ctrl[B_BRT] = m_flags[3] ^ m_flags[1];
                            else e_ctrl[B_BRT] = nzvc[2];
                        end
                    endcase
                end
                P_MEMW, P_MEMR: begin
                    e_state = 3'd3;
                    e_ctrl[4:2] = 3'b010; e_ctrl[B_ALS] = 1'b1;
                    e_ctrl[B_MRD] = (cls == C_LDUR);
                    e_ctrl[B_MWR] = (cls == C_STUR);
                    if (p == P_MEMR && cls == C_STUR) begin
                        e_ctrl[B_PCW] = 1'b1; e_ctrl[B_DONE] = 1'b1;
                    end
                end
                default: begin
                    e_state = 3'd4;
                    e_ctrl[B_RGW] = 1'b1; e_ctrl[B_PCW] = 1'b1; e_ctrl[B_DONE] = 1'b1;
                    e_ctrl[B_M2R] = (cls == C_LDUR);
                end
            endcase
            @(negedge clk);
            checks++;
            if ({state, obs_ctrl, flags} !== {e_state, e_ctrl, m_flags}) begin
                errors++;
                $display("FAIL %s cycle%0d phase%0d: got state=%0d ctrl=%h flags=%b, expected state=%0d ctrl=%h flags=%b",
                         tag, cyc, p, state, obs_ctrl, flags, e_state, e_ctrl, m_flags);
            end
            if (InstrDone === 1'b1 && done_at < 0) done_at = cyc + 1;
            cyc++;
            @(posedge clk); #1;
            if (p == P_EXEC && (cls == C_ADDS || cls == C_SUBS)) m_flags = nzvc;
        end
        checks++;
        if (done_at !== base) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", tag, done_at, base);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) begin
            imem_ready = 1'b1; dmem_ready = 1'($urandom); instruction = $urandom;
            {negative, zero, overflow, carry_out} = 4'($urandom);
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (obs_ctrl !== 16'h0) begin
                errors++;
                $display("FAIL reset_ctrl: got %h, expected 0000", obs_ctrl);
            end
            checks++;
            if (state !== 3'd0 || flags !== 4'b0000) begin
                errors++;
                $display("FAIL reset_state: got state=%0d flags=%b, expected 0/0000", state, flags);
            end
        end
        imem_ready = 1'b0;
        reset = 1'b1;
        m_flags = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_addi();
        run_instr(32'h9100_0421, 0, 0, "addi");
    endtask

    task automatic test_flags_blt();
        frc_en = 1'b1; frc_nzvc = 4'b1001;
        run_instr(make_instr(C_SUBS), 0, 0, "subs_nc");
        frc_en = 1'b0;
        checks++;
        if (flags !== 4'b1001) begin
            errors++;
            $display("FAIL subs_flags: got %b, expected 1001", flags);
        end
        run_instr(make_instr(C_BLT), 0, 0, "blt_taken");
        frc_en = 1'b1; frc_nzvc = 4'b1011;
        run_instr(make_instr(C_SUBS), 0, 0, "subs_nvc");
        frc_en = 1'b0;
        run_instr(make_instr(C_BLT), 0, 0, "blt_not_taken");
    endtask

    task automatic test_ldur_stall();
        run_instr(make_instr(C_LDUR), 0, 3, "ldur_stall");
    endtask

    task automatic test_stur_abort();
        frc_en = 1'b1; frc_nzvc = 4'b0110;
        run_instr(make_instr(C_ADDS), 0, 0, "adds_setup");
        frc_en = 1'b0;
        dmem_ready = 1'b0;
        instruction = make_instr(C_STUR); imem_ready = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0; instruction = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== 3'd3 || MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL stur_mem1: got state=%0d MemWrite=%b, expected 3/1", state, MemWrite);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_ctrl !== 16'h0) begin
            errors++;
            $display("FAIL stur_abort_ctrl: got %h, expected 0000", obs_ctrl);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        m_flags = 4'b0000;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || flags !== 4'b0000 || PCWrite !== 1'b0) begin
            errors++;
            $display("FAIL stur_abort_after: got state=%0d flags=%b PCWrite=%b, expected 0/0000/0",
                     state, flags, PCWrite);
        end
        @(posedge clk); #1;
        run_instr(make_instr(C_STUR), 0, 1, "stur_after_abort");
    endtask

    task automatic test_imem_stall();
        run_instr(make_instr(C_EOR), 5, 0, "imem_stall");
    endtask

    task automatic test_illegal_cbz();
        run_instr(32'hFFFF_FFFF, 0, 0, "illegal_ones");
        frc_en = 1'b1; frc_nzvc = 4'b0100;
        run_instr(make_instr(C_CBZ), 0, 0, "cbz_taken");
        frc_nzvc = 4'b1011;
        run_instr(make_instr(C_CBZ), 0, 0, "cbz_not_taken");
        frc_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cls, iw, dw;
        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 11);
            iw  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            dw  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            run_instr(make_instr(cls), iw, dw, "random");
        end
    endtask

    initial begin
        reset = 1'b0; instruction = 32'h0; imem_ready = 1'b0; dmem_ready = 1'b0;
        zero = 1'b0; negative = 1'b0; overflow = 1'b0; carry_out = 1'b0;
        m_flags = 4'b0000;
        test_reset();
        test_addi();
        test_flags_blt();
        test_ldur_stall();
        test_stur_abort();
        test_imem_stall();
        test_illegal_cbz();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
